alu_share_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (inputs a, b, s; output f) between two requesters, e.g. the switch panel and an autonomous test sequencer.
- Accepts operations through valid/ready handshakes and arbitrates round-robin.
- Drives registered operands to the ALU, captures f, and returns it to the winning requester on its own valid/ready response channel.
- Keeps a completed-operation count for display on the seven-segment digits.

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/alu_share_arbiter_rr_arb2.sv | 24 ++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and default sizes for the two-requester ALU sharing arbiter.
package alu_arb_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_SEL_W = 2;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-request round-robin grant logic; purely combinational, pointer kept by the parent.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // On a tie the requester that did not win last time goes first.
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered operands, one execute cycle, then a per-requester response.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = DEFAULT_SEL_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_s,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_s,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_f,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_f,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_f,

    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output state_t           dbg_state
);

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both high. A source holds valid and payload until that edge; ready may
    // depend combinationally on valid. Request ready is only ever given in IDLE,
    // and response payload stays constant while valid is high and ready is low.

    state_t           state_q;
    state_t           state_d;
    req_id_t          owner_q;
    req_id_t          last_grant_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [SEL_W-1:0] alu_s_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] op_count_q;

    logic [1:0]       grant;
    logic             arb_enable;
    logic             accept;
    req_id_t          grant_id;
    logic             owner_ready;
    logic             rsp_fire;

    assign arb_enable = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign accept      = grant[0] | grant[1];
    assign grant_id    = grant[1];
    assign owner_ready = (owner_q == 1'b1) ? rsp1_ready : rsp0_ready;
    assign rsp_fire    = (state_q == RESP) && owner_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are only loaded on an accepted request, so the ALU inputs are
    // quiet while idle; a reset mid-operation drops the result unanswered.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            result_q     <= '0;
            op_count_q   <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            if (accept) begin
                alu_a_q      <= (grant_id == 1'b1) ? req1_a : req0_a;
                alu_b_q      <= (grant_id == 1'b1) ? req1_b : req0_b;
                alu_s_q      <= (grant_id == 1'b1) ? req1_s : req0_s;
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == EXEC) begin
                result_q <= alu_f;
            end
            if (rsp_fire) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign rsp0_valid = (state_q == RESP) && (owner_q == 1'b0);
    assign rsp1_valid = (state_q == RESP) && (owner_q == 1'b1);
    assign rsp0_f     = result_q;
    assign rsp1_f     = result_q;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;

    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with an adder ALU stub.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SEL_W-1:0] req0_s, req1_s;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_f, rsp1_f;
    logic [WIDTH-1:0] alu_a, alu_b, alu_f;
    logic [SEL_W-1:0] alu_s;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    state_t           dbg_state;

    alu_share_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_s     (req1_s),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_f     (rsp0_f),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_f     (rsp1_f),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_f      (alu_f),
        .busy       (busy),
        .op_count   (op_count),
        .dbg_state  (dbg_state)
    );

    // ALU stub: 4-bit add, wraps mod 16
    assign alu_f = alu_a + alu_b;

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_id_q[$];
    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] s;
        logic [WIDTH-1:0] exp_f;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic id, input logic v, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [SEL_W-1:0] s);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_s = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_s = s;
        end
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        drive_req(1'b0, 1'b0, '0, '0, '0);
        drive_req(1'b1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_id_q.delete();
        exp_count = 0;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] f, input logic id);
        exp_q.push_back(f);
        exp_id_q.push_back(id);
    endtask

    // Called at a negedge where a response is expected to be presented.
    task automatic check_rsp(input logic id);
        logic [WIDTH-1:0] ef;
        logic             eid;
        check("rsp_valid_owner", 32'(id ? rsp1_valid : rsp0_valid), 32'd1);
        check("rsp_valid_other", 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got response with nothing expected at %0t", $time);
        end else begin
            ef  = exp_q.pop_front();
            eid = exp_id_q.pop_front();
            check("rsp_id", 32'(id), 32'(eid));
            check("rsp_f", 32'(id ? rsp1_f : rsp0_f), 32'(ef));
        end
    endtask

    // From the negedge of the grant cycle: EXEC, then RESP, then handshake.
    task automatic finish_granted(input logic id, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [SEL_W-1:0] s);
        tick;
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
        sample;
        check("exec_state", 32'(dbg_state), 32'(EXEC));
        check("exec_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("exec_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_s", 32'(alu_s), 32'(s));
        tick;
        sample;
        check("resp_state", 32'(dbg_state), 32'(RESP));
        check_rsp(id);
        tick;
        exp_count++;
    endtask

    task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] exp_f);
        tick;
        drive_req(id, 1'b1, a, b, s);
        sample;
        check("grant", 32'({req1_ready, req0_ready}), (id ? 32'd2 : 32'd1));
        push_exp(exp_f, id);
        finish_granted(id, a, b, s);
        sample;
        check("idle_after_op", 32'(dbg_state), 32'(IDLE));
        check("op_count", 32'(op_count), 32'(CNT_W'(exp_count)));
    endtask

    // Requesters keep valid high and present fresh operands after each grant.
    task automatic stream(input int n_ops, input logic use0, input logic use1,
                          input logic first_id, input int budget);
        int grants;
        int done;
        int idle_run;
        int cyc;
        logic exp_next;
        logic g0, g1;
        logic [WIDTH-1:0] ef;
        grants = 0; done = 0; idle_run = 0; cyc = 0;
        exp_next = first_id;
        tick;
        if (use0) drive_req(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        if (use1) drive_req(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        while (done < n_ops && cyc < budget) begin
            sample;
            g0 = req0_ready;
            g1 = req1_ready;
            if (!busy) idle_run++;
            if (g0 || g1) begin
                check("stream_onehot", 32'(g0 & g1), 32'd0);
                check("stream_grant_id", 32'(g1), 32'(exp_next));
                if (grants > 0) check("idle_gap", 32'(idle_run), 32'd1);
                ef = g1 ? 4'(req1_a + req1_b) : 4'(req0_a + req0_b);
                push_exp(ef, g1);
                grants++;
                if (use0 && use1) exp_next = ~exp_next;
            end
            if (rsp0_valid || rsp1_valid) begin
                check_rsp(rsp1_valid);
                done++;
                exp_count++;
                idle_run = 0;
            end
            tick;
            if (g0 || g1) begin
                if (grants >= n_ops) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end else begin
                    drive_req(g1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
                end
            end
            cyc++;
        end
        if (done < n_ops) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: got %0d responses expected %0d", done, n_ops);
        end
        sample;
        check("stream_op_count", 32'(op_count), 32'(CNT_W'(exp_count)));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{id: 1'b0, a: 4'd3,  b: 4'd5,  s: 2'd0, exp_f: 4'd8};
        vecs[1] = '{id: 1'b1, a: 4'd7,  b: 4'd9,  s: 2'd1, exp_f: 4'd0};
        vecs[2] = '{id: 1'b0, a: 4'd15, b: 4'd15, s: 2'd2, exp_f: 4'd14};
        vecs[3] = '{id: 1'b1, a: 4'd0,  b: 4'd0,  s: 2'd3, exp_f: 4'd0};
        vecs[4] = '{id: 1'b0, a: 4'd10, b: 4'd4,  s: 2'd1, exp_f: 4'd14};
        vecs[5] = '{id: 1'b1, a: 4'd6,  b: 4'd9,  s: 2'd0, exp_f: 4'd15};
        vecs[6] = '{id: 1'b0, a: 4'd8,  b: 4'd8,  s: 2'd2, exp_f: 4'd0};
        vecs[7] = '{id: 1'b1, a: 4'd1,  b: 4'd2,  s: 2'd3, exp_f: 4'd3};

        apply_reset;
        sample;
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        check("reset_alu", 32'({alu_a, alu_b, alu_s}), 32'd0);
        check("reset_rsp_f", 32'(rsp0_f), 32'd0);
        check("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);

        // single-requester operations from the table, one at a time
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_f);
        end

        // simultaneous requests after reset: requester 0 wins the first tie
        apply_reset;
        drive_req(1'b0, 1'b1, 4'd1, 4'd1, 2'd0);
        drive_req(1'b1, 1'b1, 4'd7, 4'd9, 2'd0);
        sample;
        check("tie_grant0", 32'({req1_ready, req0_ready}), 32'd1);
        push_exp(4'd2, 1'b0);
        finish_granted(1'b0, 4'd1, 4'd1, 2'd0);
        sample;
        check("tie_grant1", 32'({req1_ready, req0_ready}), 32'd2);
        push_exp(4'd0, 1'b1);
        finish_granted(1'b1, 4'd7, 4'd9, 2'd0);
        sample;
        check("tie_op_count", 32'(op_count), 32'd2);

        // both requesters streaming: alternate 0,1,0,1
        stream(4, 1'b1, 1'b1, 1'b0, 60);

        // response back-pressure on requester 1 with requester 0 waiting
        rsp1_ready = 1'b0;
        tick;
        drive_req(1'b1, 1'b1, 4'd12, 4'd7, 2'd1);
        sample;
        check("hold_grant", 32'({req1_ready, req0_ready}), 32'd2);
        push_exp(4'd3, 1'b1);
        tick;
        req1_valid = 1'b0;
        drive_req(1'b0, 1'b1, 4'd2, 4'd2, 2'd0);
        sample;
        check("hold_exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
        tick;
        for (int i = 0; i < 5; i++) begin
            sample;
            check("hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("hold_rsp1_f", 32'(rsp1_f), 32'd3);
            check("hold_rsp0_valid", 32'(rsp0_valid), 32'd0);
            check("hold_req0_ready", 32'(req0_ready), 32'd0);
            check("hold_state", 32'(dbg_state), 32'(RESP));
            tick;
        end
        rsp1_ready = 1'b1;
        sample;
        check_rsp(1'b1);
        tick;
        exp_count++;
        sample;
        check("after_hold_grant", 32'({req1_ready, req0_ready}), 32'd1);
        push_exp(4'd4, 1'b0);
        finish_granted(1'b0, 4'd2, 4'd2, 2'd0);
        sample;
        check("after_hold_count", 32'(op_count), 32'(CNT_W'(exp_count)));

        // reset while a response is pending
        rsp0_ready = 1'b0;
        tick;
        drive_req(1'b0, 1'b1, 4'd9, 4'd9, 2'd3);
        sample;
        check("rstmid_grant", 32'({req1_ready, req0_ready}), 32'd1);
        push_exp(4'd2, 1'b0);
        tick;
        req0_valid = 1'b0;
        tick;
        sample;
        check("rstmid_rsp0_valid", 32'(rsp0_valid), 32'd1);
        tick;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_id_q.delete();
        exp_count = 0;
        rsp0_ready = 1'b1;
        sample;
        check("rstmid_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'(IDLE));
        check("rstmid_op_count", 32'(op_count), 32'd0);
        check("rstmid_alu", 32'({alu_a, alu_b, alu_s}), 32'd0);
        do_op(1'b1, 4'd5, 4'd6, 2'd2, 4'd11);

        // counter wrap: 256 operations from requester 0 alone
        apply_reset;
        sample;
        stream(256, 1'b1, 1'b0, 1'b0, 1200);
        check("wrap_op_count_zero", 32'(op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
